// File: rtl/dm_ext.sv
// dm_ext: word-organised data memory for the MIPS MEM stage.
//   - byte/half/word loads and stores, little-endian lanes, sign/zero extension
//   - alignment, size and range error checking
//   - valid/ready request interface with RD_LAT-cycle pipelined responses
//   - post-reset clearing sweep that zeroes every word, one word per clock
// Optional feature: define DM_TRACE_EN to print a trace line for every
// committed store (PC, word address, merged word).
//
// FSM states
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_CLEAR | sweeping zeros into the array, requests ignored, busy=1
//   S_RUN   | accepting one request per cycle, req_ready=1

module dm_ext #(
  parameter int DEPTH  = 3072,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [AW-1:0] clr_idx;
  logic          clr_last;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic [29:0]   widx;
  logic [AW-1:0] midx;
  logic [1:0]    lane;
  logic          out_of_range;
  logic          req_err;
  logic          st_commit;
  logic [31:0]   rd_word;
  logic [31:0]   merged_word;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_val;
  logic [31:0]   ld_data;

  logic [RD_LAT-1:0] pipe_v;
  logic [RD_LAT-1:0] pipe_e;
  logic [31:0]       pipe_d [RD_LAT];

  assign clr_last = (clr_idx == AW'(DEPTH - 1));

  // State register: reset always restarts the clearing sweep.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: leave CLEAR on the edge that writes the last word.
  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (clr_last) state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_CLEAR;
    endcase
  end

  // State outputs: busy while sweeping, ready once running.
  always_comb begin
    busy      = 1'b0;
    req_ready = 1'b0;
    case (state)
      S_CLEAR: busy      = 1'b1;
      S_RUN:   req_ready = 1'b1;
      default: busy      = 1'b1;
    endcase
  end

  // Sweep counter: walks word indices 0..DEPTH-1 while clearing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_idx <= '0;
    end else if (state == S_CLEAR) begin
      clr_idx <= clr_last ? '0 : clr_idx + AW'(1);
    end
  end

  assign accept       = req_valid & req_ready;
  assign widx         = req_addr[31:2];
  assign midx         = req_addr[AW+1:2];
  assign lane         = req_addr[1:0];
  assign out_of_range = ({2'b00, widx} >= 32'(DEPTH));

  // Request checking: illegal size, misalignment, or index past the array.
  always_comb begin
    req_err = out_of_range;
    case (req_size)
      2'b01:   if (req_addr[0])      req_err = 1'b1;
      2'b10:   if (req_addr[1:0] != 2'b00) req_err = 1'b1;
      2'b11:   req_err = 1'b1;
      default: ;
    endcase
  end

  assign st_commit = accept & req_we & ~req_err;

  // Combinational word read; out-of-range indices never reach a response.
  assign rd_word = out_of_range ? 32'h0 : mem[midx];

  // Store lane merge: replace only the addressed byte/half, keep the rest.
  always_comb begin
    merged_word = rd_word;
    case (req_size)
      2'b00:   merged_word[{lane, 3'b000} +: 8]         = req_wdata[7:0];
      2'b01:   merged_word[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
      2'b10:   merged_word = req_wdata;
      default: merged_word = rd_word;
    endcase
  end

  assign ld_byte = rd_word[{lane, 3'b000} +: 8];
  assign ld_half = rd_word[{req_addr[1], 4'b0000} +: 16];

  // Load alignment and extension, done before stage 1 captures the value.
  always_comb begin
    ld_val = 32'h0;
    case (req_size)
      2'b00:   ld_val = req_sext ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
      2'b01:   ld_val = req_sext ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
      2'b10:   ld_val = rd_word;
      default: ld_val = 32'h0;
    endcase
  end

  // Stores and errored requests always answer with zero data.
  assign ld_data = (req_we | req_err) ? 32'h0 : ld_val;

  // Memory array: sweep writes while clearing, committed stores while running.
  // Only written synchronously so the array can map onto block RAM.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[clr_idx] <= 32'h0;
    end else if (st_commit) begin
      mem[midx] <= merged_word;
`ifdef DM_TRACE_EN
      $display("@%h: *%h <= %h", req_pc, {req_addr[31:2], 2'b00}, merged_word);
`endif
    end
  end

`ifndef DM_TRACE_EN
  // The PC is only consumed by the trace output.
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

  // Response pipeline: stage 0 captures at acceptance, later stages delay it.
  // Empty slots carry zero data so the outputs read zero when nothing is due.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_v <= '0;
      pipe_e <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_d[i] <= 32'h0;
      end
    end else begin
      pipe_v[0] <= accept;
      pipe_e[0] <= accept & req_err;
      pipe_d[0] <= accept ? ld_data : 32'h0;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_e[i] <= pipe_e[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign resp_valid = pipe_v[RD_LAT-1];
  assign resp_err   = pipe_e[RD_LAT-1];
  assign resp_rdata = pipe_d[RD_LAT-1];

endmodule

// File: tb/tb_dm_ext.sv
// Bench for dm_ext: two instances (RD_LAT=1 and RD_LAT=3) share one request
// stream and are compared every cycle against a byte-array reference model.
module tb_dm_ext;

  localparam int DEPTH = 16;
  localparam int HLEN  = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_sext = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_pc = '0;

  logic        a_ready, a_valid, a_err, a_busy;
  logic [31:0] a_rdata;
  logic        b_ready, b_valid, b_err, b_busy;
  logic [31:0] b_rdata;

  always #5 clk = ~clk;

  dm_ext #(.DEPTH(DEPTH), .RD_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(a_ready),
    .req_we(req_we), .req_size(req_size), .req_sext(req_sext),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(a_valid), .resp_rdata(a_rdata), .resp_err(a_err), .busy(a_busy)
  );

  dm_ext #(.DEPTH(DEPTH), .RD_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(b_ready),
    .req_we(req_we), .req_size(req_size), .req_sext(req_sext),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(b_valid), .resp_rdata(b_rdata), .resp_err(b_err), .busy(b_busy)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference state: memory as bytes, per-edge expected responses.
  logic [7:0]  mb [DEPTH*4];
  bit          hv [HLEN];
  bit          he [HLEN];
  logic [31:0] hd [HLEN];
  int          ne = 0;
  int          clr_left = DEPTH;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // One clock edge of the reference: accept, check, store or load bytes.
  task automatic model_edge();
    int nb;
    int base;
    bit acc;
    bit e;
    longint v;
    hv[ne] = 1'b0;
    he[ne] = 1'b0;
    hd[ne] = 32'h0;
    if (!reset) begin
      clr_left = DEPTH;
    end else begin
      acc = req_valid && (clr_left == 0);
      if (acc) begin
        hv[ne] = 1'b1;
        nb = 1 << req_size;
        e = (req_size == 2'b11) || ((req_addr % nb) != 0) || ((req_addr >> 2) >= DEPTH);
        he[ne] = e;
        if (!e) begin
          base = int'(req_addr);
          if (req_we) begin
            for (int b = 0; b < nb; b++) mb[base+b] = req_wdata[8*b +: 8];
          end else begin
            v = 0;
            for (int b = 0; b < nb; b++) v = v | (longint'(mb[base+b]) << (8*b));
            if (req_sext && nb < 4 && ((v >> (8*nb-1)) & 1) == 1)
              v = v - (longint'(1) << (8*nb));
            hd[ne] = v[31:0];
          end
        end
      end
      if (clr_left > 0) clr_left--;
    end
    ne++;
  endtask

  task automatic check_all();
    int k;
    int j;
    k = ne - 1;
    j = ne - 3;
    chk1("l1_valid", a_valid, hv[k]);
    chk ("l1_rdata", a_rdata, hd[k]);
    chk1("l1_err",   a_err,   he[k]);
    chk1("l1_busy",  a_busy,  clr_left > 0);
    chk1("l1_ready", a_ready, clr_left == 0);
    chk1("l3_valid", b_valid, (j >= 0) ? hv[j] : 1'b0);
    chk ("l3_rdata", b_rdata, (j >= 0) ? hd[j] : 32'h0);
    chk1("l3_err",   b_err,   (j >= 0) ? he[j] : 1'b0);
    chk1("l3_busy",  b_busy,  clr_left > 0);
    chk1("l3_ready", b_ready, clr_left == 0);
  endtask

  task automatic cyc(input bit v, input bit we, input logic [1:0] sz, input bit sx,
                     input logic [31:0] a, input logic [31:0] wd);
    req_valid = v;
    req_we    = we;
    req_size  = sz;
    req_sext  = sx;
    req_addr  = a;
    req_wdata = wd;
    req_pc    = $urandom;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic rnd_cyc();
    logic [1:0]  sz;
    logic [31:0] a;
    sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, DEPTH*4 + 7));
    cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), sz,
        1'($urandom_range(0, 1)), a, $urandom);
  endtask

  // Asynchronous reset assertion, checked one time unit later.
  task automatic rst_on();
    reset = 1'b0;
    #1;
    clr_left = DEPTH;
    for (int i = 0; i < HLEN; i++) begin
      hv[i] = 1'b0; he[i] = 1'b0; hd[i] = 32'h0;
    end
    for (int i = 0; i < DEPTH*4; i++) mb[i] = 8'h00;
    chk1("rst_busy",   a_busy,  1'b1);
    chk1("rst_ready",  a_ready, 1'b0);
    chk1("rst_valid1", a_valid, 1'b0);
    chk ("rst_rdata1", a_rdata, 32'h0);
    chk1("rst_err1",   a_err,   1'b0);
    chk1("rst_valid3", b_valid, 1'b0);
    chk ("rst_rdata3", b_rdata, 32'h0);
    chk1("rst_busy3",  b_busy,  1'b1);
  endtask

  task automatic expect1(input string tag, input logic [31:0] d, input logic e);
    chk1({tag, "_valid"}, a_valid, 1'b1);
    chk ({tag, "_rdata"}, a_rdata, d);
    chk1({tag, "_err"},   a_err,   e);
  endtask

  initial begin
    @(negedge clk);

    // Power-on clear: reset low 3 cycles, then a 16-edge sweep with junk requests.
    rst_on();
    idle(3);
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) rnd_cyc();
    chk1("sweep_done_ready", a_ready, 1'b1);
    cyc(1'b1, 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0);
    expect1("lw_3c_clear", 32'h0, 1'b0);

    // Dirty a word, then reset mid-sweep and confirm the full sweep re-runs.
    cyc(1'b1, 1'b1, 2'b10, 1'b0, 32'h3C, 32'hDEADBEEF);
    expect1("sw_3c", 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0);
    expect1("lw_3c", 32'hDEADBEEF, 1'b0);
    rst_on();
    idle(2);
    reset = 1'b1;
    idle(6);
    rst_on();
    idle(1);
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) rnd_cyc();
    chk1("resweep_done", a_busy, 1'b0);
    cyc(1'b1, 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0);
    expect1("lw_3c_recleared", 32'h0, 1'b0);

    // Word/byte merge and extension.
    cyc(1'b1, 1'b1, 2'b10, 1'b0, 32'h8, 32'h11223344);
    cyc(1'b1, 1'b1, 2'b00, 1'b0, 32'h9, 32'h556677AA);
    expect1("sb_9", 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    expect1("lw_8_merged", 32'h1122AA44, 1'b0);
    cyc(1'b1, 1'b0, 2'b00, 1'b1, 32'h9, 32'h0);
    expect1("lb_9", 32'hFFFFFFAA, 1'b0);
    cyc(1'b1, 1'b0, 2'b00, 1'b0, 32'h9, 32'h0);
    expect1("lbu_9", 32'h000000AA, 1'b0);

    // Halfword.
    cyc(1'b1, 1'b1, 2'b01, 1'b0, 32'hA, 32'h12348001);
    cyc(1'b1, 1'b0, 2'b01, 1'b1, 32'hA, 32'h0);
    expect1("lh_a", 32'hFFFF8001, 1'b0);
    cyc(1'b1, 1'b0, 2'b01, 1'b0, 32'hA, 32'h0);
    expect1("lhu_a", 32'h00008001, 1'b0);
    cyc(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    expect1("lw_8_half", 32'h8001AA44, 1'b0);

    // Errors.
    cyc(1'b1, 1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
    expect1("lw_misaligned", 32'h0, 1'b1);
    cyc(1'b1, 1'b1, 2'b01, 1'b0, 32'h5, 32'hFFFFFFFF);
    expect1("sh_misaligned", 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    expect1("lw_4_unchanged", 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 2'b11, 1'b0, 32'h8, 32'h0);
    expect1("size_11", 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 2'b10, 1'b0, 32'(DEPTH*4), 32'h0);
    expect1("lw_range", 32'h0, 1'b1);
    cyc(1'b1, 1'b1, 2'b00, 1'b0, 32'(DEPTH*4), 32'h5A);
    expect1("sb_range", 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 2'b10, 1'b0, 32'(DEPTH*4 - 4), 32'h0);
    expect1("lw_last_word", 32'h0, 1'b0);

    // Back-to-back loads; the RD_LAT=3 instance answers two edges later.
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b1, 2'b10, 1'b0, 32'(16 + 4*i), 32'hA0A00000 + 32'(i));
    cyc(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    expect1("b2b_0", 32'hA0A00000, 1'b0);
    cyc(1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    expect1("b2b_1", 32'hA0A00001, 1'b0);
    cyc(1'b1, 1'b0, 2'b10, 1'b0, 32'h18, 32'h0);
    chk("lat3_0", b_rdata, 32'hA0A00000);
    cyc(1'b1, 1'b0, 2'b10, 1'b0, 32'h1C, 32'h0);
    chk("lat3_1", b_rdata, 32'hA0A00001);
    cyc(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D);
    chk("lat3_2", b_rdata, 32'hA0A00002);
    cyc(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    chk("lat3_3", b_rdata, 32'hA0A00003);
    expect1("st_then_ld", 32'hCAFEF00D, 1'b0);
    idle(3);

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) rnd_cyc();
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dm_ext.md
Name: dm_ext

Overview:
- Parametrised successor data memory for the single-cycle/pipelined MIPS datapath: word-organised RAM with byte/halfword/word loads and stores, sign/zero extension, and alignment/range error checking.
- Adds a valid/ready request interface with configurable read latency.
- Adds a post-reset clearing sweep, so contents are zeroed without an asynchronous multi-thousand-word reset.
- Sits between the ALU/MEM stage and the writeback mux.

Parameters:
- DEPTH, 3072, number of 32-bit words; word index = req_addr[31:2], valid range 0..DEPTH-1.
- RD_LAT, 1, cycles from request acceptance to resp_valid; legal range 1..4.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_sext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_pc  in  32  PC of the issuing instruction, used for trace only.
- resp_valid  out  1  one-cycle pulse per accepted request.
- resp_rdata  out  32  load result, extended; 0 for stores and errors.
- resp_err  out  1  request was misaligned, out of range, or illegal size.
- busy  out  1  clearing sweep in progress.

Behaviour:
- Reset asserted (reset=0), asynchronously:
  - FSM goes to CLEAR with clear counter = 0.
  - busy=1, req_ready=0.
  - Pipeline valid bits, resp_valid, resp_rdata and resp_err all go to 0.
  - Memory array is not touched asynchronously.
- FSM CLEAR:
  - On each rising edge after reset deasserts, writes 0 to word[counter], then counter+1.
  - After the edge that writes word DEPTH-1, moves to RUN: busy=0, req_ready=1.
  - The sweep takes exactly DEPTH edges.
  - Requests presented during CLEAR are ignored; no response is produced.
- Reset reasserted mid-sweep: counter restarts at 0 and the full sweep is repeated.
- FSM RUN:
  - req_ready=1 every cycle; the block is fully pipelined at one request per cycle.
  - A request is accepted on a rising edge with req_valid=1 and req_ready=1.
- Error check at acceptance (any one condition sets resp_err):
  - size=11.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Word index >= DEPTH.
  - An erroring store writes nothing.
  - An erroring request gets resp_rdata=0 and resp_err=1.
- Store (little-endian lanes), committed at the accepting edge:
  - Byte: bits [8*a+7:8*a] <= wdata[7:0], where a = addr[1:0].
  - Half: bits [16*h+15:16*h] <= wdata[15:0], where h = addr[1].
  - Word: full word <= wdata.
  - Unselected bytes are preserved.
- Load:
  - Word is read combinationally at the accepting edge and captured into pipeline stage 1.
  - The selected byte/half is shifted to bit 0, then sign-extended if req_sext=1, otherwise zero-extended.
  - Extension is done before or within stage 1.
- Ordering:
  - A load accepted the edge after a store to the same word returns the new data.
  - A load and a store are never simultaneous (one request per edge).
- Latency:
  - The response for a request accepted at edge N appears after edge N+RD_LAT-1, so it is visible during the cycle following that edge.
  - RD_LAT=1 means resp_valid is high in the cycle immediately after acceptance.
  - Responses appear in acceptance order.
  - Stores also return a response: rdata=0 and the computed err.
- Outputs are registered and hold their values while resp_valid=0; resp_rdata is zeroed when no response is due.

Optional Feature:
- Macro: DM_TRACE_EN.
- Defined: every committed, non-erroring store executes $display("@%h: *%h <= %h", req_pc, {req_addr[31:2],2'b00}, merged_word) at the write edge. merged_word is the full 32-bit word after lane merging.
- Undefined: no display statements are compiled; behaviour is otherwise identical.

Test Plan:
- Clearing sweep, DEPTH=16, RD_LAT=1: reset low 3 cycles, then high -> busy=1 for exactly 16 edges, then req_ready=1. A word load of addr 0x3C returns 0 with err=0.
- Reset mid-sweep, DEPTH=16: pull reset low at sweep edge 7, release -> busy stays high for a further 16 edges.
- Word/byte merge:
  - SW 0x11223344 @0x8.
  - Then SB 0xAA @0x9 -> LW @0x8 returns 0x1122AA44.
  - LB @0x9 with sext=1 returns 0xFFFFFFAA.
  - LBU @0x9 returns 0x000000AA.
- Halfword: SH 0x8001 @0xA, then LH @0xA -> 0xFFFF8001. LHU @0xA -> 0x00008001. Word @0x8 upper half = 0x8001.
- Errors:
  - LW @0x6 -> resp_err=1, rdata=0.
  - SH @0x5 -> err=1 and memory unchanged.
  - size=11 -> err=1.
  - LW at word index DEPTH -> err=1.
- Latency, RD_LAT=3: four back-to-back loads of distinct words -> four consecutive resp_valid pulses starting 3 cycles after the first acceptance, data in order. A store followed next cycle by a load of the same word -> new data returned.
